rv32i_instruction_memory: RTL and testbench



---
 rtl/rv32i_instruction_memory.sv | 136 +++++++++++++
 tb/tb_rv32i_instruction_memory.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_instruction_memory.sv
// rv32i_instruction_memory
//
// Responder side of the instruction-fetch interface. The fetch stage sends
// word requests over a valid/ready channel. Instruction words come back
// through a 2-entry in-order response FIFO with one cycle of read latency.
// A program-load write port fills the memory. A flush input lets the fetch
// stage drop stale responses when it redirects on a branch or jump.
//
// Ports:
//   clk        clock; all logic runs on the rising edge
//   rst        synchronous, active-high reset (memory contents survive it)
//   req_valid  fetch request valid
//   req_ready  a request can be accepted this cycle
//   req_addr   byte address (PC) of the requested instruction
//   rsp_valid  the response at the FIFO head is valid
//   rsp_ready  the fetch stage consumes the head response
//   rsp_data   instruction word at the FIFO head
//   rsp_err    the head response was misaligned or out of range
//   flush      drop all queued responses and any request offered this cycle
//   load_we    program-load write enable
//   load_addr  byte address for the program load
//   load_data  word to write
module rv32i_instruction_memory #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] ERR_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  input  logic        flush,
  input  logic        load_we,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  logic [31:0]   mem [DEPTH];

  logic [31:0]   slot_data [2];
  logic          slot_err  [2];
  logic          rd_ptr;
  logic          wr_ptr;
  logic [1:0]    count;

  logic [31:0]   head_data;
  logic          head_err;

  logic [AW-1:0] req_idx;
  logic          req_err;
  logic [31:0]   push_data;
  logic [AW-1:0] load_idx;
  logic          load_ok;
  logic          push;
  logic          pop;
  logic          unused_load_bits;

  assign req_idx   = req_addr[AW+1:2];
  assign req_err   = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= DEPTH_W);
  assign push_data = req_err ? ERR_INSTR : mem[req_idx];

  assign load_idx  = load_addr[AW+1:2];
  assign load_ok   = load_we && (load_addr[31:2] < DEPTH_W);
  // The byte offset of a load address is ignored on purpose.
  assign unused_load_bits = ^load_addr[1:0];

  // req_ready does not look at rsp_ready. This keeps a combinational path
  // from the consumer from reaching back into the request channel.
  assign req_ready = !rst && !load_we && !flush && (count != 2'd2);
  assign rsp_valid = !rst && (count != 2'd0);
  assign rsp_data  = rst ? 32'h0 : head_data;
  assign rsp_err   = rst ? 1'b0  : head_err;

  assign push = req_valid && req_ready;
  // A flush overrides a pop in the same cycle. The flush still empties the
  // FIFO, so the pop simply has no effect.
  assign pop  = rsp_valid && rsp_ready && !flush;

  // The memory has no reset. Writes are allowed even while rst is high.
  always_ff @(posedge clk) begin
    if (load_ok) begin
      mem[load_idx] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      slot_data[wr_ptr] <= push_data;
      slot_err[wr_ptr]  <= req_err;
    end
  end

  // head_data/head_err mirror the FIFO head. They are updated only when a
  // new entry becomes the head, so the outputs hold their last value when
  // the FIFO drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= 2'd0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      head_data <= 32'h0;
      head_err  <= 1'b0;
    end else if (flush) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr ^ 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr ^ 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (pop && (count == 2'd2)) begin
        head_data <= slot_data[rd_ptr ^ 1'b1];
        head_err  <= slot_err[rd_ptr ^ 1'b1];
      end else if (push && ((count == 2'd0) || (pop && (count == 2'd1)))) begin
        head_data <= push_data;
        head_err  <= req_err;
      end
    end
  end

endmodule

// File: tb/tb_rv32i_instruction_memory.sv
// tb_rv32i_instruction_memory
//
// Directed testbench for rv32i_instruction_memory. Each expected value is
// worked out by hand from the stimulus.
module tb_rv32i_instruction_memory;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        flush;
  logic        load_we;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  int checks;
  int errors;

  rv32i_instruction_memory #(
    .DEPTH    (1024),
    .ERR_INSTR(32'h0000_0013)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .flush    (flush),
    .load_we  (load_we),
    .load_addr(load_addr),
    .load_data(load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge, where registered outputs
  // have settled and inputs can be changed safely.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive the request channel, then let the combinational outputs settle.
  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic rr, input logic fl);
    req_valid = v;
    req_addr  = a;
    rsp_ready = rr;
    flush     = fl;
    #1;
  endtask

  task automatic checkRsp(input string tag, input logic v, input logic [31:0] d, input logic e);
    checkOutput({tag, "_valid"}, {31'b0, rsp_valid}, {31'b0, v});
    checkOutput({tag, "_data"}, rsp_data, d);
    checkOutput({tag, "_err"}, {31'b0, rsp_err}, {31'b0, e});
  endtask

  task automatic loadWord(input logic [31:0] a, input logic [31:0] d);
    load_we   = 1'b1;
    load_addr = a;
    load_data = d;
    step();
    load_we   = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = 32'h0;
    rsp_ready = 1'b0;
    flush     = 1'b0;
    load_we   = 1'b0;
    load_addr = 32'h0;
    load_data = 32'h0;

    $display("[TB] reset");
    step();
    checkRsp("reset", 1'b0, 32'h0, 1'b0);
    checkOutput("reset_ready", {31'b0, req_ready}, 32'h0);
    rst = 1'b0;
    step();

    $display("[TB] program load and back-to-back fetch");
    loadWord(32'h0, 32'h0000_0013);
    loadWord(32'h4, 32'h0010_0093);
    loadWord(32'h8, 32'h0020_0113);
    applyStimulus(1'b1, 32'h0, 1'b1, 1'b0);
    checkOutput("t1_ready", {31'b0, req_ready}, 32'h1);
    checkOutput("t1_pre_valid", {31'b0, rsp_valid}, 32'h0);
    step();
    checkRsp("t1_w0", 1'b1, 32'h0000_0013, 1'b0);
    applyStimulus(1'b1, 32'h4, 1'b1, 1'b0);
    step();
    checkRsp("t1_w1", 1'b1, 32'h0010_0093, 1'b0);
    applyStimulus(1'b1, 32'h8, 1'b1, 1'b0);
    step();
    checkRsp("t1_w2", 1'b1, 32'h0020_0113, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    checkRsp("t1_empty_hold", 1'b0, 32'h0020_0113, 1'b0);

    $display("[TB] errored fetches");
    applyStimulus(1'b1, 32'h2, 1'b1, 1'b0);
    step();
    checkRsp("t2_misaligned", 1'b1, 32'h0000_0013, 1'b1);
    applyStimulus(1'b1, 32'h1000, 1'b1, 1'b0);
    step();
    checkRsp("t2_range", 1'b1, 32'h0000_0013, 1'b1);
    applyStimulus(1'b1, 32'h4, 1'b1, 1'b0);
    step();
    checkRsp("t2_mem_intact", 1'b1, 32'h0010_0093, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    step();

    $display("[TB] backpressure");
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0);
    step();
    checkRsp("t3_first", 1'b1, 32'h0000_0013, 1'b0);
    applyStimulus(1'b1, 32'h4, 1'b0, 1'b0);
    checkOutput("t3_ready_c1", {31'b0, req_ready}, 32'h1);
    step();
    checkRsp("t3_stable_a", 1'b1, 32'h0000_0013, 1'b0);
    applyStimulus(1'b1, 32'h8, 1'b0, 1'b0);
    checkOutput("t3_ready_full", {31'b0, req_ready}, 32'h0);
    step();
    checkRsp("t3_stable_b", 1'b1, 32'h0000_0013, 1'b0);
    applyStimulus(1'b1, 32'h8, 1'b1, 1'b0);
    checkOutput("t3_ready_full2", {31'b0, req_ready}, 32'h0);
    step();
    checkRsp("t3_pop1", 1'b1, 32'h0010_0093, 1'b0);
    checkOutput("t3_ready_after_pop", {31'b0, req_ready}, 32'h1);
    step();
    checkRsp("t3_third", 1'b1, 32'h0020_0113, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    checkRsp("t3_drained", 1'b0, 32'h0020_0113, 1'b0);

    $display("[TB] flush");
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 32'h4, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 32'h8, 1'b1, 1'b1);
    checkOutput("t4_ready_flush", {31'b0, req_ready}, 32'h0);
    step();
    checkRsp("t4_flushed", 1'b0, 32'h0000_0013, 1'b0);
    applyStimulus(1'b1, 32'h8, 1'b1, 1'b0);
    checkOutput("t4_ready_again", {31'b0, req_ready}, 32'h1);
    step();
    checkRsp("t4_refetch", 1'b1, 32'h0020_0113, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    checkRsp("t4_empty", 1'b0, 32'h0020_0113, 1'b0);

    $display("[TB] load blocks fetch");
    load_we   = 1'b1;
    load_addr = 32'h4;
    load_data = 32'hDEAD_BEEF;
    applyStimulus(1'b1, 32'h4, 1'b1, 1'b0);
    checkOutput("t5_ready_load", {31'b0, req_ready}, 32'h0);
    step();
    load_we = 1'b0;
    checkOutput("t5_no_accept", {31'b0, rsp_valid}, 32'h0);
    applyStimulus(1'b1, 32'h4, 1'b1, 1'b0);
    step();
    checkRsp("t5_new_data", 1'b1, 32'hDEAD_BEEF, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    loadWord(32'h1008, 32'h1234_5678);
    applyStimulus(1'b1, 32'h8, 1'b1, 1'b0);
    step();
    checkRsp("t5_oob_load_ignored", 1'b1, 32'h0020_0113, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    step();

    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, 32'h2, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0);
    step();
    checkRsp("t6_queued", 1'b1, 32'h0000_0013, 1'b1);
    rst = 1'b1;
    step();
    checkRsp("t6_in_reset", 1'b0, 32'h0, 1'b0);
    checkOutput("t6_ready_reset", {31'b0, req_ready}, 32'h0);
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    checkRsp("t6_after_reset", 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h4, 1'b1, 1'b0);
    step();
    checkRsp("t6_mem_kept", 1'b1, 32'hDEAD_BEEF, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
